// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-information and pipeline-control bundle between the ARM datapath (master)
// and the hazard/sequencing controller (slave).
interface pipeline_hazard_ctrl_if;
    // ID stage sources
    logic [3:0] ID_rn;
    logic [3:0] ID_rm;
    logic [3:0] ID_rd;
    logic       ID_use_rn;
    logic       ID_use_rm;
    logic       ID_use_rd;
    logic       ID_cond;
    logic       ID_br_taken;
    // Downstream destinations
    logic [3:0] EX_rd;
    logic       EX_we;
    logic       EX_load;
    logic       EX_s;
    logic [3:0] MEM_rd;
    logic       MEM_we;
    logic       MEM_acc;
    logic       mem_ack;
    logic [3:0] WB_rd;
    logic       WB_we;
    // Controls back to the datapath
    logic [1:0] fwdA_sel;
    logic [1:0] fwdB_sel;
    logic [1:0] fwdC_sel;
    logic       PC_ld;
    logic       IFID_ld;
    logic       IFID_clr;
    logic       IDEX_nop;
    logic       EXMEM_ld;
    logic       MEMWB_ld;
    logic       mem_req;
    logic       mem_err;
    logic [1:0] state;

    modport master (
        output ID_rn, ID_rm, ID_rd, ID_use_rn, ID_use_rm, ID_use_rd, ID_cond, ID_br_taken,
        output EX_rd, EX_we, EX_load, EX_s, MEM_rd, MEM_we, MEM_acc, mem_ack, WB_rd, WB_we,
        input  fwdA_sel, fwdB_sel, fwdC_sel, PC_ld, IFID_ld, IFID_clr, IDEX_nop,
        input  EXMEM_ld, MEMWB_ld, mem_req, mem_err, state
    );

    modport slave (
        input  ID_rn, ID_rm, ID_rd, ID_use_rn, ID_use_rm, ID_use_rd, ID_cond, ID_br_taken,
        input  EX_rd, EX_we, EX_load, EX_s, MEM_rd, MEM_we, MEM_acc, mem_ack, WB_rd, WB_we,
        output fwdA_sel, fwdB_sel, fwdC_sel, PC_ld, IFID_ld, IFID_clr, IDEX_nop,
        output EXMEM_ld, MEMWB_ld, mem_req, mem_err, state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage ARM pipeline: operand forwarding,
// load-use/flag bubbles, branch flush, data-memory freeze. Define HAZARD_STATS_EN for stall_cnt.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b11
    } state_t;

    state_t            state_reg, state_next;
    logic [WCNT_W-1:0] wcnt_reg, wcnt_next;

    // Per-source forwarding: index 0 = Rn, 1 = Rm, 2 = Rd (store data)
    logic [11:0] src_regs;
    logic [2:0]  src_use;
    logic [5:0]  fwd_bus;
    logic [2:0]  ld_use_hit;

    assign src_regs = {hz.ID_rd, hz.ID_rm, hz.ID_rn};
    assign src_use  = {hz.ID_use_rd, hz.ID_use_rm, hz.ID_use_rn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fwd
            logic [3:0] src;
            logic       valid_src;
            logic       ex_hit, mem_hit, wb_hit;

            assign src       = src_regs[4*gi +: 4];
            assign valid_src = src_use[gi] && (src != 4'd15);
            assign ex_hit    = valid_src && hz.EX_we  && (src == hz.EX_rd);
            assign mem_hit   = valid_src && hz.MEM_we && (src == hz.MEM_rd);
            assign wb_hit    = valid_src && hz.WB_we  && (src == hz.WB_rd);

            // A load result in EX is not yet available; the bubble delays the consumer
            // until the load reaches MEM, so this source skips the EX path.
            assign fwd_bus[2*gi +: 2] = (ex_hit && !hz.EX_load) ? 2'b01 :
                                        mem_hit                 ? 2'b10 :
                                        wb_hit                  ? 2'b11 : 2'b00;
            assign ld_use_hit[gi] = ex_hit && hz.EX_load;
        end
    endgenerate

    logic load_use;
    logic flag_stall;
    logic bubble_req;
    logic mem_req_int;
    logic freeze;

    assign load_use    = |ld_use_hit;
    assign flag_stall  = hz.ID_cond && hz.EX_s;
    assign bubble_req  = load_use || flag_stall;
    assign mem_req_int = hz.MEM_acc && (state_reg != ST_ERR);
    assign freeze      = mem_req_int && !hz.mem_ack;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= ST_RUN;
            wcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (hz.MEM_acc && !hz.mem_ack) begin
                    state_next = ST_MEM_WAIT;
                    wcnt_next  = WCNT_ONE;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ack) begin
                    state_next = ST_RUN;
                    wcnt_next  = '0;
                end else if (wcnt_reg == WCNT_MAX) begin
                    state_next = ST_ERR;
                end else begin
                    wcnt_next = wcnt_reg + WCNT_ONE;
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_RUN;
                wcnt_next  = '0;
            end
        endcase
    end

    // Pipeline controls, priority: reset > ERR > freeze > bubble > flush > normal
    always_comb begin
        hz.PC_ld    = 1'b1;
        hz.IFID_ld  = 1'b1;
        hz.IFID_clr = 1'b0;
        hz.IDEX_nop = 1'b0;
        hz.EXMEM_ld = 1'b1;
        hz.MEMWB_ld = 1'b1;
        if (!Rst_n || (state_reg == ST_ERR)) begin
            hz.PC_ld    = 1'b0;
            hz.IFID_ld  = 1'b0;
            hz.IDEX_nop = 1'b1;
            hz.EXMEM_ld = 1'b0;
            hz.MEMWB_ld = 1'b0;
        end else if (freeze) begin
            hz.PC_ld    = 1'b0;
            hz.IFID_ld  = 1'b0;
            hz.EXMEM_ld = 1'b0;
            hz.MEMWB_ld = 1'b0;
        end else if (bubble_req) begin
            hz.PC_ld    = 1'b0;
            hz.IFID_ld  = 1'b0;
            hz.IDEX_nop = 1'b1;
        end else if (hz.ID_br_taken) begin
            hz.IFID_clr = 1'b1;
        end
    end

    assign hz.fwdA_sel = Rst_n ? fwd_bus[1:0] : 2'b00;
    assign hz.fwdB_sel = Rst_n ? fwd_bus[3:2] : 2'b00;
    assign hz.fwdC_sel = Rst_n ? fwd_bus[5:4] : 2'b00;
    assign hz.mem_req  = Rst_n && mem_req_int;
    assign hz.mem_err  = (state_reg == ST_ERR);
    assign hz.state    = state_reg;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             stall_act;

    assign stall_act = (state_reg != ST_ERR) && (freeze || bubble_req);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall_act && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4); checks forwarding, bubbles,
// flush, memory freeze, timeout-to-ERR and asynchronous reset recovery.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] C_NORM   = 6'b110011;
    localparam logic [5:0] C_BUBBLE = 6'b000111;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_FLUSH  = 6'b111011;
    localparam logic [5:0] C_HALT   = 6'b000100;

    logic Clk;
    logic Rst_n;
    int   n_vec;
    int   n_err;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
    logic [7:0] stall_cnt;
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .hz(hz), .stall_cnt(stall_cnt)
    );
`else
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .hz(hz)
    );
`endif

    // {PC_ld, IFID_ld, IFID_clr, IDEX_nop, EXMEM_ld, MEMWB_ld}
    logic [5:0] ctrl;
    assign ctrl = {hz.PC_ld, hz.IFID_ld, hz.IFID_clr, hz.IDEX_nop, hz.EXMEM_ld, hz.MEMWB_ld};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.ID_rn = 4'd0; hz.ID_rm = 4'd0; hz.ID_rd = 4'd0;
        hz.ID_use_rn = 1'b0; hz.ID_use_rm = 1'b0; hz.ID_use_rd = 1'b0;
        hz.ID_cond = 1'b0; hz.ID_br_taken = 1'b0;
        hz.EX_rd = 4'd0; hz.EX_we = 1'b0; hz.EX_load = 1'b0; hz.EX_s = 1'b0;
        hz.MEM_rd = 4'd0; hz.MEM_we = 1'b0; hz.MEM_acc = 1'b0; hz.mem_ack = 1'b0;
        hz.WB_rd = 4'd0; hz.WB_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        Rst_n = 1'b0;
        clear_inputs();
        // Hazards presented during reset must not leak to the outputs
        hz.MEM_acc = 1'b1;
        hz.ID_rn = 4'd2; hz.ID_use_rn = 1'b1; hz.EX_rd = 4'd2; hz.EX_we = 1'b1;
        @(negedge Clk);
        chk("rst_ctrl", 32'(ctrl), 32'(C_HALT));
        chk("rst_fwdA", 32'(hz.fwdA_sel), 32'd0);
        chk("rst_mem_req", 32'(hz.mem_req), 32'd0);
        chk("rst_state", 32'(hz.state), 32'd0);
        chk("rst_mem_err", 32'(hz.mem_err), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge Clk);
        Rst_n = 1'b1;
        clear_inputs();
        tick();

        // EX beats MEM for Rn
        hz.ID_rn = 4'd3; hz.ID_use_rn = 1'b1;
        hz.EX_rd = 4'd3; hz.EX_we = 1'b1;
        hz.MEM_rd = 4'd3; hz.MEM_we = 1'b1;
        @(negedge Clk);
        chk("fwd_ex_wins", 32'(hz.fwdA_sel), 32'd1);
        chk("fwd_ex_ctrl", 32'(ctrl), 32'(C_NORM));
        tick();
        clear_inputs();

        // MEM beats WB, EX not writing
        hz.ID_rm = 4'd7; hz.ID_use_rm = 1'b1; hz.ID_rd = 4'd7; hz.ID_use_rd = 1'b1;
        hz.EX_rd = 4'd7; hz.MEM_rd = 4'd7; hz.MEM_we = 1'b1; hz.WB_rd = 4'd7; hz.WB_we = 1'b1;
        @(negedge Clk);
        chk("fwd_mem_B", 32'(hz.fwdB_sel), 32'd2);
        chk("fwd_mem_C", 32'(hz.fwdC_sel), 32'd2);
        tick();
        clear_inputs();

        // R15 never forwarded, unused source stays RF, WB-only match
        hz.ID_rn = 4'd15; hz.ID_use_rn = 1'b1; hz.EX_rd = 4'd15; hz.EX_we = 1'b1;
        hz.ID_rm = 4'd4;  hz.ID_rd = 4'd4; hz.ID_use_rd = 1'b1;
        hz.MEM_rd = 4'd4; hz.WB_rd = 4'd4; hz.WB_we = 1'b1;
        @(negedge Clk);
        chk("fwd_r15_A", 32'(hz.fwdA_sel), 32'd0);
        chk("fwd_unused_B", 32'(hz.fwdB_sel), 32'd0);
        chk("fwd_wb_C", 32'(hz.fwdC_sel), 32'd3);
        tick();
        clear_inputs();

        // Load-use on Rm: one bubble, then the load in MEM forwards
        hz.ID_rm = 4'd5; hz.ID_use_rm = 1'b1;
        hz.EX_rd = 4'd5; hz.EX_we = 1'b1; hz.EX_load = 1'b1;
        @(negedge Clk);
        chk("ldu_ctrl", 32'(ctrl), 32'(C_BUBBLE));
        chk("ldu_fwdB", 32'(hz.fwdB_sel), 32'd0);
        tick();
        hz.EX_rd = 4'd0; hz.EX_we = 1'b0; hz.EX_load = 1'b0;
        hz.MEM_rd = 4'd5; hz.MEM_we = 1'b1;
        @(negedge Clk);
        chk("ldu_next_fwdB", 32'(hz.fwdB_sel), 32'd2);
        chk("ldu_next_ctrl", 32'(ctrl), 32'(C_NORM));
        tick();
        clear_inputs();

        // Flag stall masks a taken branch
        hz.ID_cond = 1'b1; hz.EX_s = 1'b1; hz.ID_br_taken = 1'b1;
        @(negedge Clk);
        chk("flag_bubble_ctrl", 32'(ctrl), 32'(C_BUBBLE));
        tick();
        hz.EX_s = 1'b0;
        @(negedge Clk);
        chk("branch_flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        clear_inputs();

        // Load into R15 never stalls
        hz.ID_rn = 4'd15; hz.ID_use_rn = 1'b1;
        hz.EX_rd = 4'd15; hz.EX_we = 1'b1; hz.EX_load = 1'b1;
        @(negedge Clk);
        chk("ldu_r15_ctrl", 32'(ctrl), 32'(C_NORM));
        tick();
        clear_inputs();

        // Zero-wait access, then a stray ack with no access
        hz.MEM_acc = 1'b1; hz.mem_ack = 1'b1;
        @(negedge Clk);
        chk("zw_ctrl", 32'(ctrl), 32'(C_NORM));
        chk("zw_mem_req", 32'(hz.mem_req), 32'd1);
        tick();
        hz.MEM_acc = 1'b0;
        @(negedge Clk);
        chk("zw_state", 32'(hz.state), 32'd0);
        chk("stray_ack_mem_req", 32'(hz.mem_req), 32'd0);
        tick();
        clear_inputs();

        // Three-cycle wait; a load-use hazard during the freeze is subsumed
        hz.MEM_acc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hz.mem_ack = (i == 3);
            hz.ID_rm = 4'd6; hz.ID_use_rm = (i == 1);
            hz.EX_rd = 4'd6; hz.EX_we = (i == 1); hz.EX_load = (i == 1);
            @(negedge Clk);
            chk($sformatf("wait%0d_state", i), 32'(hz.state), (i == 0) ? 32'd0 : 32'd1);
            chk($sformatf("wait%0d_ctrl", i), 32'(ctrl), (i < 3) ? 32'(C_FREEZE) : 32'(C_NORM));
            chk($sformatf("wait%0d_mem_req", i), 32'(hz.mem_req), 32'd1);
            tick();
        end
        clear_inputs();
        @(negedge Clk);
        chk("wait_done_state", 32'(hz.state), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
`endif
        tick();

        // No ack: RUN, 4 x MEM_WAIT, then ERR
        hz.MEM_acc = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge Clk);
            chk($sformatf("tmo%0d_state", j), 32'(hz.state),
                (j == 0) ? 32'd0 : (j < 5) ? 32'd1 : 32'd3);
            tick();
        end
        @(negedge Clk);
        chk("err_mem_err", 32'(hz.mem_err), 32'd1);
        chk("err_mem_req", 32'(hz.mem_req), 32'd0);
        chk("err_ctrl", 32'(ctrl), 32'(C_HALT));
        tick();
        hz.MEM_acc = 1'b0; hz.mem_ack = 1'b1;
        @(negedge Clk);
        chk("err_sticky_state", 32'(hz.state), 32'd3);
        tick();
        hz.mem_ack = 1'b0;
        @(negedge Clk);
        chk("err_sticky_mem_err", 32'(hz.mem_err), 32'd1);
        tick();

        // Asynchronous reset clears ERR immediately
        Rst_n = 1'b0;
        #1;
        chk("rst_err_state", 32'(hz.state), 32'd0);
        chk("rst_err_mem_err", 32'(hz.mem_err), 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();

        // Reset mid MEM_WAIT
        hz.MEM_acc = 1'b1;
        @(negedge Clk);
        chk("mid_req_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick();
        @(negedge Clk);
        chk("mid_wait_state", 32'(hz.state), 32'd1);
        tick();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(hz.state), 32'd0);
        chk("mid_rst_ctrl", 32'(ctrl), 32'(C_HALT));
        chk("mid_rst_mem_req", 32'(hz.mem_req), 32'd0);
`ifdef HAZARD_STATS_EN
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        hz.MEM_acc = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        @(negedge Clk);
        chk("post_rst_state", 32'(hz.state), 32'd0);
        chk("post_rst_ctrl", 32'(ctrl), 32'(C_NORM));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
